// File: rtl/dist_sched_if.sv
// Measurement-box and host-side signal bundle for the distance scheduler.
interface dist_sched_if;
  logic        enable;
  logic        fire_measure;
  logic        done_measure;
  logic        err_measure;
  logic [31:0] data_measure;
  logic        dist_valid;
  logic [31:0] dist_data;
  logic        dist_err;
  logic [7:0]  err_cnt;

  modport master (
    input  enable, done_measure, err_measure, data_measure,
    output fire_measure, dist_valid, dist_data, dist_err, err_cnt
  );

  modport slave (
    output enable, done_measure, err_measure, data_measure,
    input  fire_measure, dist_valid, dist_data, dist_err, err_cnt
  );
endinterface

// File: rtl/dist_sched.sv
// Periodic measurement scheduler with timeout guard, 4-sample moving average
// and error-burst reporting.
module dist_sched #(
  parameter int unsigned GAP_CYC   = 2_000_000,
  parameter int unsigned TIMEOUT   = 4_000_000,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic clk_sys,
  input  logic rst,
  dist_sched_if.master bus
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FIRE = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_PROC = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             timeout;
  logic             gap_end;

  logic [31:0]      samp_data;
  logic             samp_err;
  logic [3:0][31:0] win;
  logic [33:0]      sum;
  logic [33:0]      sum_nxt;
  logic [31:0]      oldest;
  logic [2:0]       nvalid;
  logic [2:0]       nvalid_inc;
  logic [3:0]       cons_err;
  logic [3:0]       cons_inc;

  logic             fire_q;
  logic             valid_q;
  logic [31:0]      data_q;
  logic             derr_q;
  logic [7:0]       err_cnt_q;

  assign timeout = (state == S_WAIT) && (to_cnt == TO_W'(TIMEOUT - 1)) && !bus.done_measure;
  assign gap_end = (gap_cnt == GAP_W'(GAP_CYC - 1));

  // State register
  always_ff @(posedge clk_sys) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.enable) state_nxt = S_FIRE;
      S_FIRE: state_nxt = S_WAIT;
      S_WAIT: if (bus.done_measure || timeout) state_nxt = S_PROC;
      S_PROC: state_nxt = S_GAP;
      S_GAP:  if (gap_end) state_nxt = bus.enable ? S_FIRE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait and gap counters run only in their own state
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      to_cnt  <= '0;
      gap_cnt <= '0;
      fire_q  <= 1'b0;
    end else begin
      to_cnt  <= (state == S_WAIT) ? to_cnt + TO_W'(1) : '0;
      gap_cnt <= (state == S_GAP)  ? gap_cnt + GAP_W'(1) : '0;
      fire_q  <= (state_nxt == S_FIRE);
    end
  end

  // Oldest entry only leaves the sum once the window is full
  always_comb begin
    oldest     = (nvalid == 3'd4) ? win[3] : 32'd0;
    sum_nxt    = sum + 34'(samp_data) - 34'(oldest);
    nvalid_inc = (nvalid == 3'd4) ? 3'd4 : nvalid + 3'd1;
    cons_inc   = cons_err + 4'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      samp_data <= '0;
      samp_err  <= 1'b0;
      win       <= '0;
      sum       <= '0;
      nvalid    <= '0;
      cons_err  <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      derr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state == S_WAIT) begin
        if (bus.done_measure) begin
          samp_data <= bus.data_measure;
          samp_err  <= bus.err_measure;
        end else if (timeout) begin
          samp_err  <= 1'b1;
        end
      end
      if (state == S_PROC) begin
        if (!samp_err) begin
          win      <= {win[2:0], samp_data};
          sum      <= sum_nxt;
          nvalid   <= nvalid_inc;
          cons_err <= '0;
          if (nvalid_inc == 3'd4) begin
            data_q  <= sum_nxt[33:2];
            derr_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end else begin
          if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
          // Burst of failures discards the window and reports it
          if (cons_inc == 4'(ERR_LIMIT)) begin
            nvalid   <= '0;
            sum      <= '0;
            cons_err <= '0;
            derr_q   <= 1'b1;
            valid_q  <= 1'b1;
          end else begin
            cons_err <= cons_inc;
          end
        end
      end
    end
  end

  assign bus.fire_measure = fire_q;
  assign bus.dist_valid   = valid_q;
  assign bus.dist_data    = data_q;
  assign bus.dist_err     = derr_q;
  assign bus.err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_dist_sched.sv
// Directed bench for dist_sched: averaging, error bursts, timeout, enable and reset control.
module tb_dist_sched;

  localparam int unsigned GAP_CYC   = 4;
  localparam int unsigned TIMEOUT   = 50;
  localparam int unsigned ERR_LIMIT = 3;

  logic clk_sys = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   fire_cnt = 0;

  dist_sched_if bus ();

  dist_sched #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (bus.fire_measure) fire_cnt <= fire_cnt + 1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed no end expected end before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_fire();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_sys);
      if (bus.fire_measure) seen = 1'b1;
    end
    if (!seen) chk("fire_wait", 32'd0, 32'd1);
  endtask

  // Called at a negedge: done for exactly one cycle, then check no early pulse
  task automatic drive_done(input logic [31:0] d, input logic e);
    bus.done_measure = 1'b1;
    bus.data_measure = d;
    bus.err_measure  = e;
    @(negedge clk_sys);
    bus.done_measure = 1'b0;
    bus.err_measure  = 1'b0;
    bus.data_measure = '0;
    chk("valid_early", 32'(bus.dist_valid), 32'd0);
  endtask

  task automatic meas(input logic [31:0] d, input logic e, input int dly);
    wait_fire();
    repeat (dly) @(negedge clk_sys);
    drive_done(d, e);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                            input logic e, input logic [7:0] c);
    @(negedge clk_sys);
    chk({tag, "_valid"},   32'(bus.dist_valid), 32'(v));
    chk({tag, "_data"},    bus.dist_data, d);
    chk({tag, "_err"},     32'(bus.dist_err), 32'(e));
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(c));
  endtask

  initial begin
    int c0;
    int fc;
    rst = 1'b1;
    bus.enable       = 1'b0;
    bus.done_measure = 1'b0;
    bus.err_measure  = 1'b0;
    bus.data_measure = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_fire", 32'(bus.fire_measure), 32'd0);
    expect_out("rst", 1'b0, 32'd0, 1'b0, 8'd0);
    rst = 1'b0;
    bus.enable = 1'b1;

    // Window fill and first averages
    meas(32'd100, 1'b0, 1); expect_out("s1", 1'b0, 32'd0, 1'b0, 8'd0);
    meas(32'd200, 1'b0, 3); expect_out("s2", 1'b0, 32'd0, 1'b0, 8'd0);
    meas(32'd300, 1'b0, 1); expect_out("s3", 1'b0, 32'd0, 1'b0, 8'd0);
    meas(32'd400, 1'b0, 2); expect_out("s4", 1'b1, 32'd250, 1'b0, 8'd0);
    meas(32'd9,   1'b1, 1); expect_out("iso_err", 1'b0, 32'd250, 1'b0, 8'd1);
    meas(32'd600, 1'b0, 1); expect_out("s600", 1'b1, 32'd375, 1'b0, 8'd1);
    meas(32'd500, 1'b0, 1); expect_out("s500", 1'b1, 32'd450, 1'b0, 8'd1);

    // Error burst flushes the window
    meas(32'd0, 1'b1, 1); expect_out("b1", 1'b0, 32'd450, 1'b0, 8'd2);
    meas(32'd0, 1'b1, 1); expect_out("b2", 1'b0, 32'd450, 1'b0, 8'd3);
    meas(32'd0, 1'b1, 1); expect_out("b3", 1'b1, 32'd450, 1'b1, 8'd4);
    meas(32'd10, 1'b0, 1); expect_out("f1", 1'b0, 32'd450, 1'b1, 8'd4);
    meas(32'd20, 1'b0, 1); expect_out("f2", 1'b0, 32'd450, 1'b1, 8'd4);
    meas(32'd30, 1'b0, 1); expect_out("f3", 1'b0, 32'd450, 1'b1, 8'd4);
    meas(32'd40, 1'b0, 1); expect_out("f4", 1'b1, 32'd25, 1'b0, 8'd4);

    // Missing done: timeout then next fire
    wait_fire();
    c0 = cyc;
    wait_fire();
    chk("to_spacing", 32'(cyc - c0), 32'(TIMEOUT + GAP_CYC + 2));
    chk("to_err_cnt", 32'(bus.err_cnt), 32'd5);
    chk("to_no_pulse", 32'(bus.dist_valid), 32'd0);
    // done on the exact timeout cycle wins
    repeat (TIMEOUT) @(negedge clk_sys);
    drive_done(32'd1000, 1'b0);
    expect_out("to_edge", 1'b1, 32'd272, 1'b0, 8'd5);

    // enable dropped in S_WAIT: measurement completes, then idle
    wait_fire();
    @(negedge clk_sys);
    bus.enable = 1'b0;
    @(negedge clk_sys);
    drive_done(32'd2000, 1'b0);
    expect_out("en_drop", 1'b1, 32'd767, 1'b0, 8'd5);
    fc = fire_cnt;
    repeat (40) @(negedge clk_sys);
    chk("idle_no_fire", 32'(fire_cnt), 32'(fc));
    bus.enable = 1'b1;
    @(negedge clk_sys);
    chk("fire_t1", 32'(bus.fire_measure), 32'd1);
    @(negedge clk_sys);
    chk("fire_1cyc", 32'(bus.fire_measure), 32'd0);
    drive_done(32'd4000, 1'b0);
    expect_out("retain", 1'b1, 32'd1760, 1'b0, 8'd5);

    // Spurious done in S_GAP is ignored
    @(negedge clk_sys);
    drive_done(32'd5, 1'b1);
    chk("spur_err_cnt", 32'(bus.err_cnt), 32'd5);
    chk("spur_data", bus.dist_data, 32'd1760);
    @(negedge clk_sys);
    chk("spur_valid", 32'(bus.dist_valid), 32'd0);
    chk("spur_err_cnt2", 32'(bus.err_cnt), 32'd5);

    // Error counter saturation
    for (int i = 0; i < 299; i++) meas(32'd0, 1'b1, 1);
    meas(32'd0, 1'b1, 1);
    expect_out("sat", 1'b1, 32'd1760, 1'b1, 8'd255);

    // Reset in S_WAIT abandons the measurement
    wait_fire();
    @(negedge clk_sys);
    rst = 1'b1;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    chk("mid_rst_fire", 32'(bus.fire_measure), 32'd0);
    expect_out("mid_rst", 1'b0, 32'd0, 1'b0, 8'd0);
    drive_done(32'd777, 1'b0);
    expect_out("late_done", 1'b0, 32'd0, 1'b0, 8'd0);
    @(negedge clk_sys);
    chk("late_valid", 32'(bus.dist_valid), 32'd0);
    chk("late_fire", 32'(bus.fire_measure), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dist_sched.md
# dist_sched

Measurement scheduler and smoothing filter downstream of the ultrasonic measurement box. Repeatedly fires `fire_measure`, collects `data_measure`/`err_measure` on `done_measure`, and guards against a missing `done_measure` with a timeout. Averages the last 4 good samples and publishes one filtered distance per full window. Also reports error bursts and keeps an error count for the host register block.

## Interface
- `GAP_CYC`, default 2_000_000: idle cycles between the end of one measurement and the next fire; must be ≥1.
- `TIMEOUT`, default 4_000_000: max cycles in S_WAIT before the measurement is declared failed; must be ≥2.
- `ERR_LIMIT`, default 3: consecutive failed measurements that flush the window; range 1–15.
- `clk_sys` input 1: system clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: level; run continuous measurement while high.
- `fire_measure` output 1: one-cycle start pulse to the measurement box.
- `done_measure` input 1: one-cycle completion pulse from the measurement box.
- `err_measure` input 1: failure flag, valid with `done_measure`.
- `data_measure` input 32: raw echo time, valid with `done_measure`.
- `dist_valid` output 1: one-cycle pulse; `dist_data`/`dist_err` valid.
- `dist_data` output 32: 4-sample mean; held between pulses.
- `dist_err` output 1: set on an error-burst pulse, cleared on a data pulse; held between pulses.
- `err_cnt` output 8: total failed measurements, saturating at 255.

## Operation
- FSM states:
  - S_IDLE: go to S_FIRE when `enable`=1.
  - S_FIRE: always go to S_WAIT.
  - S_WAIT: go to S_PROC on `done_measure` or on timeout.
  - S_PROC: always go to S_GAP.
  - S_GAP: after GAP_CYC cycles, go to S_FIRE if `enable`=1, else S_IDLE.
- `fire_measure` = (state == S_FIRE); it comes straight from the state register, with no combinational path from inputs.
- Timeout counter:
  - Cleared outside S_WAIT; increments each cycle in S_WAIT.
  - Timeout is when count == TIMEOUT-1 and `done_measure`=0.
  - `done_measure` in that same cycle wins, and the sample is treated normally.
- Sample capture:
  - On `done_measure` in S_WAIT, latch `data_measure` and `err_measure`.
  - On timeout, latch a failure.
  - `done_measure` in any other state is ignored.
- Good sample (err=0) in S_PROC:
  - Shift into a 4-entry window and update the 34-bit running sum: sum + new − oldest (oldest counts as 0 while not full).
  - `nvalid` increments, saturating at 4.
  - Clear the consecutive-error counter.
  - If `nvalid` becomes or stays 4: `dist_data` = sum_new[33:2] (truncating divide), `dist_err`=0, pulse `dist_valid`.
- Failed sample (err=1 or timeout) in S_PROC:
  - `err_cnt` +1, saturating at 255.
  - Consecutive-error counter +1; the window is kept.
  - If the counter reaches ERR_LIMIT: flush the window (`nvalid`=0, sum=0), clear the counter, pulse `dist_valid` with `dist_err`=1, and leave `dist_data` unchanged.
- A value of 32'hffff_ffff with err=0 is a normal good sample.
- `enable` low: the measurement in flight completes, including S_PROC and S_GAP, then the FSM parks in S_IDLE. Window contents are retained across idle.
- Reset: state S_IDLE; window, sum, `nvalid`, and all counters 0. Reset mid-S_WAIT abandons the measurement with no output pulse.

## Timing
- Reset values: `fire_measure`=0, `dist_valid`=0, `dist_data`=0, `dist_err`=0, `err_cnt`=0.
- `enable` sampled high at cycle t in S_IDLE → `fire_measure` high at t+1 for exactly one cycle.
- `done_measure` at cycle t → S_PROC at t+1 → `dist_valid` high at t+2. `dist_data`, `dist_err` and `err_cnt` update in the same edge.
- Timeout: first S_WAIT cycle is w. If no done arrives, S_PROC is at w+TIMEOUT and the error pulse or count update follows one cycle later.
- End of S_PROC to next `fire_measure` is exactly GAP_CYC+1 cycles when `enable` stays high.
- Maximum one `dist_valid` per measurement; `dist_valid` is never high two consecutive cycles.

## Test plan
- Good-sample averaging (GAP_CYC=4, TIMEOUT=50, ERR_LIMIT=3):
  - Samples 100, 200, 300, 400 → no `dist_valid` for the first 3; the 4th gives `dist_valid` with `dist_data`=250, `dist_err`=0.
  - A 5th sample of 500 → `dist_data`=350.
- Isolated error: window full at 250, then one sample with `err_measure`=1 → no `dist_valid`, `err_cnt`=1. Next good 600 → `dist_data`=(200+300+400+600)/4=375.
- Error burst: 3 consecutive errors → `dist_valid` with `dist_err`=1 and `dist_data` still 375. Window flushed: the next 3 good samples give no pulse; the 4th gives a pulse.
- Timeout:
  - No `done_measure` → second `fire_measure` occurs TIMEOUT+GAP_CYC+2 cycles after the first; `err_cnt` increments.
  - `done_measure` on the exact timeout cycle with data 1000 → accepted as good, `err_cnt` unchanged.
- Control:
  - `enable` dropped during S_WAIT → the measurement completes and its `dist_valid` occurs, then no further `fire_measure`.
  - `rst` asserted mid-S_WAIT → all outputs return to 0, and no pulse occurs when the late `done_measure` arrives.
- Timing checks:
  - `err_cnt` saturation: 300 forced errors → `err_cnt`=255.
  - Spurious `done_measure` in S_GAP → ignored, with no output change.
